// File: rtl/axi4lite_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : axi4lite_pkg
// Description : Shared types and constants for the two-master AXI4-Lite
//               arbiter: FSM state encoding, response codes, default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package axi4lite_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } arb_state_t;

endpackage : axi4lite_pkg
`default_nettype wire

// File: rtl/axi4lite_arbiter2_rr_pick2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Combinational two-request round-robin picker. When both
//               request, the one that was not granted last time wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // Pick a single winner; a lone requester always wins
  always_comb begin
    gnt_valid = |req;
    case (req)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last;
      default: gnt_id = 1'b0;
    endcase
  end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/axi4lite_arbiter2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : axi4lite_arbiter2
// Description : Two-master to one-slave AXI4-Lite arbiter. One transaction in
//               flight, round-robin between masters, registered grant.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4lite_arbiter2
  import axi4lite_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  // master 0 (instruction fetch)
  input  logic                  m0_arvalid,
  input  logic [ADDR_WIDTH-1:0] m0_araddr,
  output logic                  m0_arready,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [1:0]            m0_rresp,
  input  logic                  m0_rready,
  input  logic                  m0_awvalid,
  input  logic [ADDR_WIDTH-1:0] m0_awaddr,
  output logic                  m0_awready,
  input  logic                  m0_wvalid,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic [3:0]            m0_wstrb,
  output logic                  m0_wready,
  output logic                  m0_bvalid,
  output logic [1:0]            m0_bresp,
  input  logic                  m0_bready,
  // master 1 (load/store)
  input  logic                  m1_arvalid,
  input  logic [ADDR_WIDTH-1:0] m1_araddr,
  output logic                  m1_arready,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [1:0]            m1_rresp,
  input  logic                  m1_rready,
  input  logic                  m1_awvalid,
  input  logic [ADDR_WIDTH-1:0] m1_awaddr,
  output logic                  m1_awready,
  input  logic                  m1_wvalid,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic [3:0]            m1_wstrb,
  output logic                  m1_wready,
  output logic                  m1_bvalid,
  output logic [1:0]            m1_bresp,
  input  logic                  m1_bready,
  // slave
  output logic                  s_arvalid,
  output logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic                  s_arready,
  input  logic                  s_rvalid,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic [1:0]            s_rresp,
  output logic                  s_rready,
  output logic                  s_awvalid,
  output logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic                  s_awready,
  output logic                  s_wvalid,
  output logic [DATA_WIDTH-1:0] s_wdata,
  output logic [3:0]            s_wstrb,
  input  logic                  s_wready,
  input  logic                  s_bvalid,
  input  logic [1:0]            s_bresp,
  output logic                  s_bready
);

  arb_state_t state_q;
  logic       owner_q;
  logic       last_q;
  logic       ar_done_q;
  logic       aw_done_q;
  logic       w_done_q;

  logic [1:0] w_req;
  logic       w_gnt_valid;
  logic       w_gnt_id;
  logic       w_win_arvalid;
  logic       w_own_arvalid;
  logic       w_own_awvalid;
  logic       w_own_wvalid;
  logic       w_own_rready;
  logic       w_own_bready;
  logic       w_arready;
  logic       w_awready;
  logic       w_wready;
  logic       w_rvalid;
  logic       w_bvalid;

  assign w_req = {m1_arvalid | m1_awvalid | m1_wvalid,
                  m0_arvalid | m0_awvalid | m0_wvalid};

  rr_pick2 u_pick (
    .req       (w_req),
    .last      (last_q),
    .gnt_valid (w_gnt_valid),
    .gnt_id    (w_gnt_id)
  );

  assign w_win_arvalid = w_gnt_id ? m1_arvalid : m0_arvalid;

  // Owner-side request/ready selection and slave payload muxing; payloads
  // are don't-care while their valid is low, so they are muxed unconditionally
  assign w_own_arvalid = owner_q ? m1_arvalid : m0_arvalid;
  assign w_own_awvalid = owner_q ? m1_awvalid : m0_awvalid;
  assign w_own_wvalid  = owner_q ? m1_wvalid  : m0_wvalid;
  assign w_own_rready  = owner_q ? m1_rready  : m0_rready;
  assign w_own_bready  = owner_q ? m1_bready  : m0_bready;
  assign s_araddr      = owner_q ? m1_araddr  : m0_araddr;
  assign s_awaddr      = owner_q ? m1_awaddr  : m0_awaddr;
  assign s_wdata       = owner_q ? m1_wdata   : m0_wdata;
  assign s_wstrb       = owner_q ? m1_wstrb   : m0_wstrb;

  // Channel gating: only the active transaction kind reaches the slave
  always_comb begin
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    w_arready = 1'b0;
    w_awready = 1'b0;
    w_wready  = 1'b0;
    w_rvalid  = 1'b0;
    w_bvalid  = 1'b0;
    case (state_q)
      RD: begin
        s_arvalid = w_own_arvalid & ~ar_done_q;
        w_arready = s_arready & ~ar_done_q;
        w_rvalid  = s_rvalid;
        s_rready  = w_own_rready;
      end
      WR: begin
        s_awvalid = w_own_awvalid & ~aw_done_q;
        w_awready = s_awready & ~aw_done_q;
        s_wvalid  = w_own_wvalid & ~w_done_q;
        w_wready  = s_wready & ~w_done_q;
        w_bvalid  = s_bvalid;
        s_bready  = w_own_bready;
      end
      default: ;
    endcase
  end

  // Route handshake signals back to the owner only
  assign m0_arready = w_arready & ~owner_q;
  assign m1_arready = w_arready &  owner_q;
  assign m0_awready = w_awready & ~owner_q;
  assign m1_awready = w_awready &  owner_q;
  assign m0_wready  = w_wready  & ~owner_q;
  assign m1_wready  = w_wready  &  owner_q;
  assign m0_rvalid  = w_rvalid  & ~owner_q;
  assign m1_rvalid  = w_rvalid  &  owner_q;
  assign m0_bvalid  = w_bvalid  & ~owner_q;
  assign m1_bvalid  = w_bvalid  &  owner_q;
  assign m0_rdata   = owner_q ? '0 : s_rdata;
  assign m1_rdata   = owner_q ? s_rdata : '0;
  assign m0_rresp   = owner_q ? RESP_OKAY : s_rresp;
  assign m1_rresp   = owner_q ? s_rresp : RESP_OKAY;
  assign m0_bresp   = owner_q ? RESP_OKAY : s_bresp;
  assign m1_bresp   = owner_q ? s_bresp : RESP_OKAY;

  // Arbitration FSM: grant in IDLE, track per-channel completion, release on R/B
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_gnt_valid) begin
            owner_q <= w_gnt_id;
            state_q <= w_win_arvalid ? RD : WR;
          end
        end
        RD: begin
          if (s_arvalid && s_arready) ar_done_q <= 1'b1;
          if (s_rvalid && s_rready) begin
            state_q   <= IDLE;
            last_q    <= owner_q;
            ar_done_q <= 1'b0;
          end
        end
        WR: begin
          if (s_awvalid && s_awready) aw_done_q <= 1'b1;
          if (s_wvalid && s_wready)   w_done_q  <= 1'b1;
          if (s_bvalid && s_bready) begin
            state_q   <= IDLE;
            last_q    <= owner_q;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule : axi4lite_arbiter2
`default_nettype wire

// File: tb/tb_axi4lite_arbiter2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_axi4lite_arbiter2
// Description : Scoreboard bench for the two-master AXI4-Lite arbiter with a
//               behavioural SRAM slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4lite_arbiter2;

  typedef struct {
    bit          is_b;
    int          id;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } exp_w_t;

  logic clk = 1'b0;
  logic rst;

  logic [1:0]  m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0]  m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [31:0] m_araddr [2];
  logic [31:0] m_rdata  [2];
  logic [31:0] m_awaddr [2];
  logic [31:0] m_wdata  [2];
  logic [1:0]  m_rresp  [2];
  logic [1:0]  m_bresp  [2];
  logic [3:0]  m_wstrb  [2];

  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
  logic [1:0]  s_rresp, s_bresp;
  logic [3:0]  s_wstrb;

  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  int     rd_delay = 1;
  int     ar_out = 0;
  int     aw_cyc = 0;
  int     w_cyc = 0;
  bit     m1_quiet = 0;
  exp_t   exp_q[$];
  exp_w_t exp_sw[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi4lite_arbiter2 #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(m_arvalid[0]), .m0_araddr(m_araddr[0]), .m0_arready(m_arready[0]),
    .m0_rvalid(m_rvalid[0]), .m0_rdata(m_rdata[0]), .m0_rresp(m_rresp[0]), .m0_rready(m_rready[0]),
    .m0_awvalid(m_awvalid[0]), .m0_awaddr(m_awaddr[0]), .m0_awready(m_awready[0]),
    .m0_wvalid(m_wvalid[0]), .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]), .m0_wready(m_wready[0]),
    .m0_bvalid(m_bvalid[0]), .m0_bresp(m_bresp[0]), .m0_bready(m_bready[0]),
    .m1_arvalid(m_arvalid[1]), .m1_araddr(m_araddr[1]), .m1_arready(m_arready[1]),
    .m1_rvalid(m_rvalid[1]), .m1_rdata(m_rdata[1]), .m1_rresp(m_rresp[1]), .m1_rready(m_rready[1]),
    .m1_awvalid(m_awvalid[1]), .m1_awaddr(m_awaddr[1]), .m1_awready(m_awready[1]),
    .m1_wvalid(m_wvalid[1]), .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]), .m1_wready(m_wready[1]),
    .m1_bvalid(m_bvalid[1]), .m1_bresp(m_bresp[1]), .m1_bready(m_bready[1]),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] ctl_bits();
    return {17'd0, m_arready, m_rvalid, m_awready, m_wready, m_bvalid,
            s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready};
  endfunction

  task automatic sb_check(input bit is_b, input int id, input logic [31:0] data, input logic [1:0] resp);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got %s m%0d data=%h resp=%0d, required nothing", is_b ? "B" : "R", id, data, resp);
    end else begin
      e = exp_q.pop_front();
      if (e.is_b != is_b || e.id != id || (!is_b && e.data !== data) || e.resp !== resp) begin
        errors++;
        $display("FAIL sb_resp: got %s m%0d data=%h resp=%0d, required %s m%0d data=%h resp=%0d",
                 is_b ? "B" : "R", id, data, resp, e.is_b ? "B" : "R", e.id, e.data, e.resp);
      end
    end
  endtask

  // Monitor: compare every master-side response handshake against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (m_rvalid[i] && m_rready[i]) sb_check(1'b0, i, m_rdata[i], m_rresp[i]);
        if (m_bvalid[i] && m_bready[i]) sb_check(1'b1, i, 32'd0, m_bresp[i]);
      end
      if (s_arvalid) begin
        chk("single_outstanding_ar", ar_out, 0);
        chk("ar_excludes_write", {31'd0, s_awvalid | s_wvalid}, 0);
      end
      if (m1_quiet)
        chk("m1_quiet", {27'd0, m_arready[1], m_rvalid[1], m_awready[1], m_wready[1], m_bvalid[1]}, 0);
    end
  end

  // Behavioural SRAM slave: always ready, read data after rd_delay cycles
  initial begin : slave
    bit h_ar, h_r, h_aw, h_w, h_b, rs, rd_pend, got_aw, got_w;
    logic [31:0] a_ar, a_aw, d_w, rd_addr, aw_a, w_d;
    logic [3:0] st_w, w_s;
    int rd_cnt;
    exp_w_t e;
    s_arready = 1; s_awready = 1; s_wready = 1;
    s_rvalid = 0; s_rdata = 0; s_rresp = 0; s_bvalid = 0; s_bresp = 0;
    rd_pend = 0; got_aw = 0; got_w = 0; rd_cnt = 0; rd_addr = 0; aw_a = 0; w_d = 0; w_s = 0;
    forever begin
      @(negedge clk);
      rs = rst;
      h_ar = s_arvalid & s_arready; a_ar = s_araddr;
      h_r  = s_rvalid & s_rready;
      h_aw = s_awvalid & s_awready; a_aw = s_awaddr;
      h_w  = s_wvalid & s_wready; d_w = s_wdata; st_w = s_wstrb;
      h_b  = s_bvalid & s_bready;
      @(posedge clk); #1;
      if (rs) begin
        s_rvalid = 0; s_bvalid = 0; rd_pend = 0; got_aw = 0; got_w = 0; ar_out = 0;
      end else begin
        if (h_r) begin s_rvalid = 0; ar_out--; end
        if (h_b) s_bvalid = 0;
        if (rd_pend) begin
          if (rd_cnt == 0) begin
            s_rvalid = 1; s_rdata = {rd_addr[15:0], 16'h0413};
            s_rresp = rd_addr[4] ? 2'b10 : 2'b00; rd_pend = 0;
          end else rd_cnt--;
        end
        if (h_ar) begin
          ar_out++; rd_addr = a_ar;
          if (rd_delay <= 1) begin
            s_rvalid = 1; s_rdata = {rd_addr[15:0], 16'h0413};
            s_rresp = rd_addr[4] ? 2'b10 : 2'b00;
          end else begin rd_pend = 1; rd_cnt = rd_delay - 2; end
        end
        if (h_aw) begin got_aw = 1; aw_a = a_aw; aw_cyc = cyc; end
        if (h_w)  begin got_w = 1; w_d = d_w; w_s = st_w; w_cyc = cyc; end
        if (got_aw && got_w) begin
          checks++;
          if (exp_sw.size() == 0) begin
            errors++;
            $display("FAIL slave_write_unexpected: got addr=%h data=%h strb=%h, required nothing", aw_a, w_d, w_s);
          end else begin
            e = exp_sw.pop_front();
            if (e.addr !== aw_a || e.data !== w_d || e.strb !== w_s) begin
              errors++;
              $display("FAIL slave_write: got addr=%h data=%h strb=%h, required addr=%h data=%h strb=%h",
                       aw_a, w_d, w_s, e.addr, e.data, e.strb);
            end
          end
          s_bvalid = 1; s_bresp = aw_a[4] ? 2'b10 : 2'b00; got_aw = 0; got_w = 0;
        end
      end
    end
  end

  task automatic push_r(input int id, input logic [31:0] data, input logic [1:0] resp);
    exp_t e;
    e.is_b = 0; e.id = id; e.data = data; e.resp = resp;
    exp_q.push_back(e);
  endtask

  task automatic push_b(input int id, input logic [1:0] resp);
    exp_t e;
    e.is_b = 1; e.id = id; e.data = 32'd0; e.resp = resp;
    exp_q.push_back(e);
  endtask

  // Issue one read; returns 1 ns after the clock edge carrying the R handshake
  task automatic do_read(input int id, input logic [31:0] addr);
    bit ar_hs, r_hs, done;
    int n;
    m_arvalid[id] = 1; m_araddr[id] = addr; done = 0; n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      ar_hs = m_arvalid[id] & m_arready[id];
      r_hs  = m_rvalid[id] & m_rready[id];
      @(posedge clk); #1; n++;
      if (ar_hs) m_arvalid[id] = 0;
      if (r_hs) done = 1;
    end
    if (!done) begin
      checks++; errors++; m_arvalid[id] = 0;
      $display("FAIL read_timeout m%0d: got no R handshake, required one for addr %h", id, addr);
    end
  endtask

  // Issue one write with W presented wdelay cycles after AW
  task automatic do_write(input int id, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int wdelay);
    bit aw_hs, w_hs, b_hs, w_started, done;
    int n;
    m_awvalid[id] = 1; m_awaddr[id] = addr; m_wdata[id] = data; m_wstrb[id] = strb;
    w_started = (wdelay == 0); m_wvalid[id] = w_started; done = 0; n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      aw_hs = m_awvalid[id] & m_awready[id];
      w_hs  = m_wvalid[id] & m_wready[id];
      b_hs  = m_bvalid[id] & m_bready[id];
      @(posedge clk); #1; n++;
      if (aw_hs) m_awvalid[id] = 0;
      if (w_hs) m_wvalid[id] = 0;
      if (!w_started && n == wdelay) begin m_wvalid[id] = 1; w_started = 1; end
      if (b_hs) done = 1;
    end
    if (!done) begin
      checks++; errors++; m_awvalid[id] = 0; m_wvalid[id] = 0;
      $display("FAIL write_timeout m%0d: got no B handshake, required one for addr %h", id, addr);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [31:0] a0 [4];
    logic [31:0] a1 [4];
    bit seen;
    int n;
    rst = 1; m_arvalid = 0; m_awvalid = 0; m_wvalid = 0; m_rready = 2'b11; m_bready = 2'b11;
    for (int i = 0; i < 2; i++) begin
      m_araddr[i] = 0; m_awaddr[i] = 0; m_wdata[i] = 0; m_wstrb[i] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl_zero", ctl_bits(), 0);
    @(posedge clk); #1; rst = 0;

    // Lone m0 read with a slow slave; grant takes one cycle
    rd_delay = 3; m1_quiet = 1;
    push_r(0, 32'h0000_0413, 2'b00);
    fork
      do_read(0, 32'h8000_0000);
      begin
        @(negedge clk);
        chk("t1_idle_s_arvalid", {31'd0, s_arvalid}, 0);
        chk("t1_idle_m0_arready", {31'd0, m_arready[0]}, 0);
        @(negedge clk);
        chk("t1_s_arvalid_rise", {31'd0, s_arvalid}, 1);
        chk("t1_s_araddr", s_araddr, 32'h8000_0000);
      end
    join
    m1_quiet = 0; rd_delay = 1;

    // m1 write, W lags AW by two cycles
    exp_sw.push_back('{addr: 32'h8000_1000, data: 32'hDEAD_BEEF, strb: 4'h3});
    push_b(1, 2'b00);
    do_write(1, 32'h8000_1000, 32'hDEAD_BEEF, 4'h3, 2);
    chk("t3_aw_before_w", {31'd0, aw_cyc < w_cyc}, 1);
    @(negedge clk);
    chk("t3_idle_after_b", ctl_bits(), 0);
    @(posedge clk); #1;

    // Both masters stream four reads each; grants must alternate starting at m0
    a0 = '{32'h8000_0100, 32'h8000_0104, 32'h8000_0108, 32'h8000_010C};
    a1 = '{32'h8000_0200, 32'h8000_0204, 32'h8000_0210, 32'h8000_020C};
    push_r(0, 32'h0100_0413, 2'b00); push_r(1, 32'h0200_0413, 2'b00);
    push_r(0, 32'h0104_0413, 2'b00); push_r(1, 32'h0204_0413, 2'b00);
    push_r(0, 32'h0108_0413, 2'b00); push_r(1, 32'h0210_0413, 2'b10);
    push_r(0, 32'h010C_0413, 2'b00); push_r(1, 32'h020C_0413, 2'b00);
    fork
      begin for (int i = 0; i < 4; i++) do_read(0, a0[i]); end
      begin for (int i = 0; i < 4; i++) do_read(1, a1[i]); end
    join

    // m1 read+write together against two m0 reads: m0, m1 read, m0, m1 write
    push_r(0, 32'h0500_0413, 2'b00);
    push_r(1, 32'h0600_0413, 2'b00);
    push_r(0, 32'h0504_0413, 2'b00);
    push_b(1, 2'b10);
    exp_sw.push_back('{addr: 32'h8000_2010, data: 32'h1234_5678, strb: 4'hF});
    fork
      begin do_read(0, 32'h8000_0500); do_read(0, 32'h8000_0504); end
      do_read(1, 32'h8000_0600);
      do_write(1, 32'h8000_2010, 32'h1234_5678, 4'hF, 0);
    join

    // m0 stalls R for five cycles while m1 waits
    push_r(0, 32'h0300_0413, 2'b00);
    push_r(1, 32'h0400_0413, 2'b00);
    m_rready[0] = 0;
    fork
      do_read(0, 32'h8000_0300);
      do_read(1, 32'h8000_0400);
      begin
        seen = 0; n = 0;
        while (!seen && n < 50) begin @(negedge clk); seen = m_rvalid[0]; n++; end
        chk("bp_rvalid_seen", {31'd0, seen}, 1);
        for (int k = 0; k < 5; k++) begin
          if (k > 0) @(negedge clk);
          chk("bp_rvalid_held", {31'd0, m_rvalid[0]}, 1);
          chk("bp_s_rready", {31'd0, s_rready}, 0);
          chk("bp_rdata_stable", m_rdata[0], 32'h0300_0413);
          chk("bp_m1_blocked", {30'd0, m_arready[1], s_arvalid}, 0);
        end
        @(posedge clk); #1; m_rready[0] = 1;
      end
    join

    // Reset in RD after the AR handshake
    rd_delay = 6;
    m_arvalid[0] = 1; m_araddr[0] = 32'h8000_0900;
    seen = 0; n = 0;
    while (!seen && n < 50) begin @(negedge clk); seen = s_arvalid & s_arready; n++; end
    chk("rst_ar_handshake_seen", {31'd0, seen}, 1);
    @(posedge clk); #1; rst = 1; m_arvalid[0] = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_rd_ctl_zero", ctl_bits(), 0);
    @(posedge clk); #1; rst = 0; rd_delay = 1;
    push_r(0, 32'h0700_0413, 2'b00);
    push_r(1, 32'h0800_0413, 2'b00);
    fork
      do_read(0, 32'h8000_0700);
      do_read(1, 32'h8000_0800);
    join

    repeat (3) @(posedge clk);
    chk("sb_drained", exp_q.size(), 0);
    chk("sw_drained", exp_sw.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_axi4lite_arbiter2
`default_nettype wire

// File: doc/axi4lite_arbiter2.md
Name: axi4lite_arbiter2

Overview:
- Two-master to one-slave AXI4-Lite arbiter. It sits directly upstream of the SRAM slave port.
- Master 0 is the IFU fetch port and master 1 is the LSU port. Both share one SRAM.
- Exactly one transaction is in flight at a time, with round-robin fairness between the masters.
- All arbitration decisions are registered. There is no combinational path from any master valid to any grant.

Parameters:
- DATA_WIDTH, 32, data bus width of every R and W channel.
- ADDR_WIDTH, 32, address width of every AR and AW channel.

Ports (mN = m0 and m1, identical sets; s = slave side):
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mN_arvalid in 1, mN_araddr in ADDR_WIDTH, mN_arready out 1: master read address.
- mN_rvalid out 1, mN_rdata out DATA_WIDTH, mN_rresp out 2, mN_rready in 1: master read data.
- mN_awvalid in 1, mN_awaddr in ADDR_WIDTH, mN_awready out 1: master write address.
- mN_wvalid in 1, mN_wdata in DATA_WIDTH, mN_wstrb in 4, mN_wready out 1: master write data.
- mN_bvalid out 1, mN_bresp out 2, mN_bready in 1: master write response.
- s_arvalid out 1, s_araddr out ADDR_WIDTH, s_arready in 1: slave read address.
- s_rvalid in 1, s_rdata in DATA_WIDTH, s_rresp in 2, s_rready out 1: slave read data.
- s_awvalid out 1, s_awaddr out ADDR_WIDTH, s_awready in 1: slave write address.
- s_wvalid out 1, s_wdata out DATA_WIDTH, s_wstrb out 4, s_wready in 1: slave write data.
- s_bvalid in 1, s_bresp in 2, s_bready out 1: slave write response.

Behaviour:
- State machine: IDLE, RD, WR.
- Registered state: owner (1 bit), last (1 bit, last granted master), ar_done, aw_done, w_done.
- Reset, applied on a synchronous rst=1 edge:
  - state=IDLE, last=1 (so m0 wins first), all done flags 0.
  - This applies even mid-transaction. Any in-flight transfer is abandoned. The slave is reset by the same rst.
- Request of master N: req_N = mN_arvalid | mN_awvalid | mN_wvalid.
- IDLE:
  - All master readies, master valids and slave valids are 0.
  - If any req_N is set, choose a winner:
    - only one requester: that master wins;
    - both requesting: the master != last wins.
  - Register owner=winner.
  - Next state is RD if the winner's arvalid=1, else WR. Read beats write within one master.
  - Arbitration latency is 1 cycle. The slave sees the request at the earliest in the cycle after it is first presented.
- RD (combinational muxing from the owner):
  - s_arvalid = owner arvalid & ~ar_done; s_araddr = owner araddr; owner arready = s_arready & ~ar_done.
  - Set ar_done on the s_arvalid & s_arready handshake.
  - Owner rvalid/rdata/rresp = s_rvalid/s_rdata/s_rresp; s_rready = owner rready.
  - On the R handshake: go to IDLE, set last=owner, clear ar_done.
  - If s_rvalid arrives in the same cycle as the AR handshake, it is forwarded normally.
- WR:
  - AW and W are forwarded independently and may complete in either order or the same cycle.
    - s_awvalid = owner awvalid & ~aw_done.
    - s_wvalid = owner wvalid & ~w_done.
    - Readies are gated the same way.
    - Set aw_done and w_done on their respective handshakes.
  - B is forwarded to the owner.
  - On the B handshake: go to IDLE, set last=owner, clear aw_done and w_done.
- Non-owner master: arready, awready, wready, rvalid and bvalid are all 0 in every state.
  - Its valid and payload must remain held; this is AXI-legal backpressure.
- Slave channels outside the active kind are driven 0:
  - in RD, s_awvalid, s_wvalid and s_bready are 0;
  - in WR, s_arvalid and s_rready are 0.
- Data and address outputs may carry don't-care values while their valid is 0. The bench checks them only when valid=1.
- Response codes pass through unmodified. The arbiter never generates an error.

Decomposition:
- Package axi4lite_pkg holds:
  - the state enum {IDLE, RD, WR};
  - response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - the default widths.
- Sub-module rr_pick2: combinational two-request round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: gnt_valid, gnt_id.

Test Plan:
- Only m0 reads 0x80000000; slave returns rdata=0x00000413 after a 3-cycle delay:
  - s_arvalid rises 1 cycle after m0_arvalid;
  - m0 sees rdata=0x00000413, rresp=0;
  - m1 outputs stay 0 throughout.
- m0 and m1 both assert arvalid in the same cycle, held for 4 back-to-back transactions each:
  - grants alternate m0, m1, m0, m1, ...;
  - exactly one AR is outstanding at the slave at any time.
- m1 writes 0x80001000 with wdata=0xDEADBEEF, wstrb=0x3, wvalid asserted 2 cycles after awvalid:
  - the slave sees AW first, then W with the same payload;
  - m1 gets bvalid with bresp=0;
  - state returns to IDLE the cycle after the B handshake.
- m1 asserts arvalid and awvalid/wvalid together:
  - the read is serviced first;
  - the write is then granted, after m0 if m0 is requesting.
- rst=1 pulsed while in RD after the AR handshake:
  - the next cycle shows IDLE, all valids and readies 0, last=1;
  - a fresh m0/m1 simultaneous request grants m0.
- Backpressure: m0 holds rready=0 for 5 cycles with s_rvalid=1:
  - s_rready stays 0;
  - rdata is held stable to m0;
  - m1's pending request is not granted until the R handshake completes.
